// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and width helpers shared by the FIFO write arbiter
// and its round-robin selector.
package fifo_arb_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
   function automatic int owner_w(input int num_req);
      return $clog2(num_req);
   endfunction
   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; finds the first set request bit
// after last, wrapping modulo N (N need not be a power of two).
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         found,
   output logic [W-1:0] index
);
   logic [W-1:0] j;
   // Walk the candidates farthest-first so the nearest set bit wins last.
   always_comb begin
      found = |req;
      index = '0;
      j = '0;
      for (int k = N; k >= 1; k--) begin
         j = W'((int'(last) + k) % N);
         if (req[j]) index = j;
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port
// among NUM_REQ write-domain requesters, gated by the FIFO full flag.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ = 4,
   parameter int MAX_BURST = 4,
   localparam int OWNER_W = owner_w(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            ack,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic                          fifo_winc,
   input  logic                          fifo_wfull,
   output logic [OWNER_W-1:0]            owner,
   output logic                          busy
);
   localparam int CNT_W = cnt_w(MAX_BURST);
   state_t state;
   logic [CNT_W-1:0] beat_cnt;
   logic [OWNER_W-1:0] last_owner, pick;
   logic found, accept, burst_end;
   logic [DATA_WIDTH-1:0] slot [NUM_REQ];
   always_comb for (int i = 0; i < NUM_REQ; i++) slot[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   rr_pick #(.N(NUM_REQ), .W(OWNER_W)) u_pick (
      .req(req), .last(last_owner), .found(found), .index(pick)
   );
   assign busy = state == ST_BURST;
   assign accept = busy & req[owner] & ~fifo_wfull;
   assign fifo_winc = accept;
   assign ack = accept ? NUM_REQ'(1) << owner : '0;
   assign fifo_wdata = busy ? slot[owner] : '0;
   // A withdrawn owner ends the burst without writing; a stalled beat never ends it.
   assign burst_end = ~req[owner] | (accept & (req_last[owner] | beat_cnt == CNT_W'(MAX_BURST - 1)));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         beat_cnt <= '0;
         last_owner <= OWNER_W'(NUM_REQ - 1);
         owner <= '0;
      end else if (state == ST_IDLE) begin
         if (found) begin
            owner <= pick;
            beat_cnt <= '0;
            state <= ST_BURST;
         end
      end else begin
         if (accept) beat_cnt <= beat_cnt + 1'b1;
         if (burst_end) begin
            state <= ST_IDLE;
            last_owner <= owner;
         end
      end
   end
   assert property (@(posedge clk) disable iff (rst) !(fifo_winc && fifo_wfull));
   assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of the FIFO write arbiter
// (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=32).
module tb_fifo_wr_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] req, req_last, ack, ack_s;
   logic [127:0] req_data;
   logic [31:0] fifo_wdata;
   logic fifo_winc, fifo_wfull, busy;
   logic [1:0] owner;
   int tests = 0, fails = 0, wcnt, hit;
   int cnt [4], pres [4], wr_seq [4], wt [4];

   fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .fifo_wdata(fifo_wdata), .fifo_winc(fifo_winc),
      .fifo_wfull(fifo_wfull), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [31:0] v);
      req_data[i*32 +: 32] = v;
   endtask

   task automatic beat(input string tag, input logic [3:0] a, input logic [31:0] d, input logic [1:0] o);
      check({tag, "_winc"}, fifo_winc, 1);
      check({tag, "_ack"}, ack, a);
      check({tag, "_wdata"}, fifo_wdata, d);
      check({tag, "_owner"}, owner, o);
   endtask

   initial begin
      rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_wfull = 1'b0;
      #2;
      check("rst_owner", owner, 0);
      check("rst_busy", busy, 0);
      check("rst_ack", ack, 0);
      check("rst_winc", fifo_winc, 0);
      check("rst_wdata", fifo_wdata, 0);
      tick(); tick();
      rst = 1'b0;
      // single requester, three-beat burst ending on req_last
      req = 4'b0001; set_slot(0, 32'hD000_0000);
      #1;
      check("t1_idle_busy", busy, 0);
      check("t1_idle_winc", fifo_winc, 0);
      tick(); #1;
      beat("t1_b0", 4'b0001, 32'hD000_0000, 0);
      check("t1_busy", busy, 1);
      tick(); set_slot(0, 32'hD000_0001); #1;
      beat("t1_b1", 4'b0001, 32'hD000_0001, 0);
      tick(); set_slot(0, 32'hD000_0002); req_last = 4'b0001; #1;
      beat("t1_b2", 4'b0001, 32'hD000_0002, 0);
      tick(); req = '0; req_last = '0; #1;
      check("t1_end_busy", busy, 0);
      check("t1_end_winc", fifo_winc, 0);
      rst = 1'b1; #1; rst = 1'b0;
      // all four requesting: forced re-arbitration every MAX_BURST beats
      for (int i = 0; i < 4; i++) begin cnt[i] = 0; set_slot(i, 32'hA000_0000 + i*16); end
      req = 4'b1111; wcnt = 0;
      for (int b = 0; b < 4; b++) begin
         #1;
         check("t2_idle_winc", fifo_winc, 0);
         check("t2_idle_busy", busy, 0);
         tick();
         for (int k = 0; k < 4; k++) begin
            #1;
            beat("t2_beat", 4'b0001 << b, 32'hA000_0000 + b*16 + k, 2'(b));
            wcnt += int'(fifo_winc);
            tick();
            cnt[b]++; set_slot(b, 32'hA000_0000 + b*16 + cnt[b]);
         end
      end
      check("t2_writes", wcnt, 16);
      req = '0;
      // owner 2 stalled by wfull while requester 1 waits
      req = 4'b0100; set_slot(2, 32'hC000_0000);
      #1;
      check("t3_idle_busy", busy, 0);
      tick(); req = 4'b0110; #1;
      beat("t3_b0", 4'b0100, 32'hC000_0000, 2);
      tick(); set_slot(2, 32'hC000_0001); #1;
      beat("t3_b1", 4'b0100, 32'hC000_0001, 2);
      tick(); set_slot(2, 32'hC000_0002); fifo_wfull = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         check("t3_full_winc", fifo_winc, 0);
         check("t3_full_ack", ack, 0);
         check("t3_full_busy", busy, 1);
         tick();
      end
      fifo_wfull = 1'b0; req_last = 4'b0100; #1;
      beat("t3_b2", 4'b0100, 32'hC000_0002, 2);
      // owner 1 withdraws after two beats while requester 3 waits
      tick(); req = 4'b0010; req_last = '0; set_slot(1, 32'hB000_0000); #1;
      check("t4_idle_busy", busy, 0);
      check("t4_idle_winc", fifo_winc, 0);
      tick(); req = 4'b1010; #1;
      beat("t4_b0", 4'b0010, 32'hB000_0000, 1);
      tick(); set_slot(1, 32'hB000_0001); #1;
      beat("t4_b1", 4'b0010, 32'hB000_0001, 1);
      tick(); req = 4'b1000; #1;
      check("t4_drop_winc", fifo_winc, 0);
      check("t4_drop_ack", ack, 0);
      check("t4_drop_busy", busy, 1);
      tick(); req = 4'b1010; set_slot(3, 32'hE000_0000); #1;
      check("t4_idle2_busy", busy, 0);
      check("t4_idle2_winc", fifo_winc, 0);
      tick(); #1;
      beat("t4_next", 4'b1000, 32'hE000_0000, 3);
      // asynchronous reset in the middle of beat 2
      tick(); set_slot(3, 32'hE000_0001); #1;
      beat("t5_b1", 4'b1000, 32'hE000_0001, 3);
      tick(); set_slot(3, 32'hE000_0002); #1;
      check("t5_b2_winc", fifo_winc, 1);
      rst = 1'b1; #1;
      check("t5_rst_winc", fifo_winc, 0);
      check("t5_rst_ack", ack, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_owner", owner, 0);
      tick();
      check("t5_rsthold_winc", fifo_winc, 0);
      rst = 1'b0; req = 4'b1011; set_slot(0, 32'hF000_0000); #1;
      check("t5_idle_busy", busy, 0);
      tick(); #1;
      beat("t5_first", 4'b0001, 32'hF000_0000, 0);
      // randomized traffic against a per-requester sequence scoreboard
      req = '0; req_last = '0;
      rst = 1'b1; #1; rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pres[i] = 0; wr_seq[i] = 0; wt[i] = 0; set_slot(i, {8'(i), 24'(0)});
      end
      for (int c = 0; c < 10000; c++) begin
         #1;
         check("rnd_full_write", fifo_winc & fifo_wfull, 0);
         if (fifo_winc) begin
            check("rnd_ack_onehot", $onehot(ack), 1);
            hit = 0;
            for (int i = 0; i < 4; i++) if (ack[i]) hit = i;
            check("rnd_owner", owner, hit);
            check("rnd_wdata", fifo_wdata, {8'(hit), 24'(wr_seq[hit])});
            wr_seq[hit]++;
         end else check("rnd_idle_ack", ack, 0);
         for (int i = 0; i < 4; i++) begin
            if (req[i] && !fifo_wfull) wt[i]++;
            if (ack[i]) begin
               check("rnd_wait", wt[i] <= 20, 1);
               wt[i] = 0;
            end
            if (!req[i]) wt[i] = 0;
         end
         ack_s = ack;
         tick();
         for (int i = 0; i < 4; i++) begin
            if (ack_s[i]) begin
               pres[i]++;
               req[i] = ($urandom % 4) != 0;
               req_last[i] = ($urandom % 3) == 0;
            end else if (!req[i]) begin
               req[i] = ($urandom % 2) != 0;
               req_last[i] = ($urandom % 3) == 0;
            end
            set_slot(i, {8'(i), 24'(pres[i])});
         end
         fifo_wfull = ($urandom % 4) == 0;
      end
      for (int i = 0; i < 4; i++) check("rnd_count", wr_seq[i], pres[i]);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
